// File: rtl/eth_pkg.sv
// Shared encodings for the Ethernet transmit scheduler: frame types, scheduler
// states and the broadcast MAC.
package eth_pkg;

  typedef enum logic [1:0] {
    TX_NONE    = 2'd0,
    TX_ARP_REQ = 2'd1,
    TX_ARP_RSP = 2'd2,
    TX_UDP     = 2'd3
  } tx_type_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    WAIT_ARP  = 2'd3
  } sched_state_e;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/eth_arp_timer.sv
// ARP answer timeout counter plus retry counter. timeout_o fires on the last
// tick of a wait window; exhausted_o fires when that timeout uses up the final retry.
module eth_arp_timer #(
  parameter int unsigned Timeout = 125000,
  parameter int unsigned Retries = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic tick_i,
  input  logic retry_clr_i,
  output logic timeout_o,
  output logic exhausted_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam int unsigned RetW = $clog2(Retries + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [RetW-1:0] retry_q, retry_d;

  assign timeout_o   = tick_i && (cnt_q == CntW'(Timeout - 1));
  assign exhausted_o = timeout_o && (retry_q == RetW'(Retries - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || timeout_o) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    retry_d = retry_q;
    if (retry_clr_i) begin
      retry_d = '0;
    end else if (timeout_o) begin
      retry_d = retry_q + RetW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Ethernet transmit scheduler: ARP resolution with retry, three-source frame
// arbitration onto the frame builder. Optional MAC ageing: ETH_TX_SCHED_CACHE_AGE_EN.
module eth_tx_sched
  import eth_pkg::*;
#(
  parameter logic [31:0] HOST_IP     = 32'h0A00_0021,
  parameter logic [31:0] CLIENT_IP   = 32'h0A00_0002,
  parameter int unsigned ARP_TIMEOUT = 125000,
  parameter int unsigned ARP_RETRIES = 3,
  parameter logic [31:0] CACHE_AGE   = 32'd125000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_arp_req_rx,
  input  logic [47:0] i_arp_req_mac,
  input  logic [31:0] i_arp_req_ip,
  input  logic [31:0] i_arp_req_tip,
  input  logic        i_arp_rsp_rx,
  input  logic [47:0] i_arp_rsp_mac,
  input  logic [31:0] i_arp_rsp_ip,
  input  logic        i_udp_req,
  input  logic [9:0]  i_udp_len,
  output logic        o_udp_ack,
  output logic        o_tx_start,
  input  logic        i_tx_done,
  output logic [1:0]  o_tx_type,
  output logic [47:0] o_tx_mac,
  output logic [31:0] o_tx_ip,
  output logic [9:0]  o_tx_len,
  output logic [47:0] o_client_mac,
  output logic        o_mac_valid,
  output logic        o_arp_fail
);

  sched_state_e state_q, state_d;
  tx_type_e     type_q, type_d;
  logic [47:0]  mac_q, mac_d, pend_mac_q, pend_mac_d, cmac_q, cmac_d;
  logic [31:0]  ip_q, ip_d, pend_ip_q, pend_ip_d;
  logic [9:0]   len_q, len_d;
  logic         start_q, start_d, ack_q, ack_d, pend_q, pend_d;
  logic         valid_q, valid_d, fail_q, fail_d;
  logic         req_hit, rsp_hit, age_expire;
  logic         tmr_clr, tmr_tick, tmr_timeout, tmr_exhausted;

  assign req_hit  = i_arp_req_rx && (i_arp_req_tip == HOST_IP);
  assign rsp_hit  = i_arp_rsp_rx && (i_arp_rsp_ip == CLIENT_IP);
  assign tmr_tick = (state_q == WAIT_ARP) && !rsp_hit && !pend_q && !valid_q;

  eth_arp_timer #(
    .Timeout(ARP_TIMEOUT),
    .Retries(ARP_RETRIES)
  ) u_arp_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (tmr_clr),
    .tick_i     (tmr_tick),
    .retry_clr_i(rsp_hit),
    .timeout_o  (tmr_timeout),
    .exhausted_o(tmr_exhausted)
  );

`ifdef ETH_TX_SCHED_CACHE_AGE_EN
  logic [31:0] age_q, age_d;

  assign age_expire = valid_q && (age_q == CACHE_AGE - 32'd1);

  always_comb begin
    age_d = age_q;
    if (rsp_hit) begin
      age_d = '0;
    end else if (valid_q) begin
      age_d = age_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end
`else
  logic unused_cache_age;
  assign age_expire       = 1'b0;
  assign unused_cache_age = ^CACHE_AGE;
`endif

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    mac_d      = mac_q;
    ip_d       = ip_q;
    len_d      = len_q;
    start_d    = 1'b0;
    ack_d      = 1'b0;
    pend_d     = pend_q;
    pend_mac_d = pend_mac_q;
    pend_ip_d  = pend_ip_q;
    cmac_d     = cmac_q;
    valid_d    = valid_q;
    fail_d     = fail_q;
    tmr_clr    = 1'b0;

    // Capture first so a request arriving this cycle can win arbitration now.
    if (req_hit) begin
      pend_d     = 1'b1;
      pend_mac_d = i_arp_req_mac;
      pend_ip_d  = i_arp_req_ip;
    end

    unique case (state_q)
      IDLE: begin
        if (pend_d) begin
          type_d  = TX_ARP_RSP;
          mac_d   = pend_mac_d;
          ip_d    = pend_ip_d;
          len_d   = '0;
          pend_d  = 1'b0;
          start_d = 1'b1;
          state_d = ISSUE;
        end else if (i_udp_req && !valid_q && !fail_q) begin
          type_d  = TX_ARP_REQ;
          mac_d   = BCAST_MAC;
          ip_d    = CLIENT_IP;
          len_d   = '0;
          start_d = 1'b1;
          state_d = ISSUE;
        end else if (i_udp_req && valid_q) begin
          type_d  = TX_UDP;
          mac_d   = cmac_q;
          ip_d    = CLIENT_IP;
          len_d   = i_udp_len;
          start_d = 1'b1;
          ack_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (i_tx_done) begin
          type_d = TX_NONE;
          if (type_q == TX_ARP_REQ) begin
            tmr_clr = 1'b1;
            state_d = WAIT_ARP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_ARP: begin
        if (rsp_hit || valid_q || pend_q) begin
          state_d = IDLE;
        end else if (tmr_timeout) begin
          if (tmr_exhausted) fail_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (age_expire) valid_d = 1'b0;
    if (rsp_hit) begin
      cmac_d  = i_arp_rsp_mac;
      valid_d = 1'b1;
      fail_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      type_q     <= TX_NONE;
      mac_q      <= '0;
      ip_q       <= '0;
      len_q      <= '0;
      start_q    <= 1'b0;
      ack_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_mac_q <= '0;
      pend_ip_q  <= '0;
      cmac_q     <= '0;
      valid_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      mac_q      <= mac_d;
      ip_q       <= ip_d;
      len_q      <= len_d;
      start_q    <= start_d;
      ack_q      <= ack_d;
      pend_q     <= pend_d;
      pend_mac_q <= pend_mac_d;
      pend_ip_q  <= pend_ip_d;
      cmac_q     <= cmac_d;
      valid_q    <= valid_d;
      fail_q     <= fail_d;
    end
  end

  assign o_tx_start   = start_q;
  assign o_udp_ack    = ack_q;
  assign o_tx_type    = type_q;
  assign o_tx_mac     = mac_q;
  assign o_tx_ip      = ip_q;
  assign o_tx_len     = len_q;
  assign o_client_mac = cmac_q;
  assign o_mac_valid  = valid_q;
  assign o_arp_fail   = fail_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed self-checking bench for eth_tx_sched; the bench plays the frame
// builder and the ARP peers. Short timeout/retry/age parameters keep runs brief.
module tb_eth_tx_sched;

  localparam logic [31:0] HOST   = 32'h0A00_0021;
  localparam logic [31:0] CLIENT = 32'h0A00_0002;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_arp_req_rx = 1'b0;
  logic [47:0] i_arp_req_mac = '0;
  logic [31:0] i_arp_req_ip = '0;
  logic [31:0] i_arp_req_tip = '0;
  logic        i_arp_rsp_rx = 1'b0;
  logic [47:0] i_arp_rsp_mac = '0;
  logic [31:0] i_arp_rsp_ip = '0;
  logic        i_udp_req = 1'b0;
  logic [9:0]  i_udp_len = '0;
  logic        i_tx_done = 1'b0;
  logic        o_udp_ack, o_tx_start, o_mac_valid, o_arp_fail;
  logic [1:0]  o_tx_type;
  logic [47:0] o_tx_mac, o_client_mac;
  logic [31:0] o_tx_ip;
  logic [9:0]  o_tx_len;

  int n_cmp = 0;
  int n_err = 0;

  eth_tx_sched #(
    .HOST_IP    (HOST),
    .CLIENT_IP  (CLIENT),
    .ARP_TIMEOUT(16),
    .ARP_RETRIES(3),
    .CACHE_AGE  (32'd100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_arp_req_rx (i_arp_req_rx),
    .i_arp_req_mac(i_arp_req_mac),
    .i_arp_req_ip (i_arp_req_ip),
    .i_arp_req_tip(i_arp_req_tip),
    .i_arp_rsp_rx (i_arp_rsp_rx),
    .i_arp_rsp_mac(i_arp_rsp_mac),
    .i_arp_rsp_ip (i_arp_rsp_ip),
    .i_udp_req    (i_udp_req),
    .i_udp_len    (i_udp_len),
    .o_udp_ack    (o_udp_ack),
    .o_tx_start   (o_tx_start),
    .i_tx_done    (i_tx_done),
    .o_tx_type    (o_tx_type),
    .o_tx_mac     (o_tx_mac),
    .o_tx_ip      (o_tx_ip),
    .o_tx_len     (o_tx_len),
    .o_client_mac (o_client_mac),
    .o_mac_valid  (o_mac_valid),
    .o_arp_fail   (o_arp_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".start"}, o_tx_start, 0);
    chk({tag, ".ack"}, o_udp_ack, 0);
    chk({tag, ".type"}, o_tx_type, 0);
    chk({tag, ".mac"}, o_tx_mac, 0);
    chk({tag, ".ip"}, o_tx_ip, 0);
    chk({tag, ".len"}, o_tx_len, 0);
    chk({tag, ".cmac"}, o_client_mac, 0);
    chk({tag, ".valid"}, o_mac_valid, 0);
    chk({tag, ".fail"}, o_arp_fail, 0);
  endtask

  task automatic set_req(input logic [47:0] mac, input logic [31:0] ip, input logic [31:0] tip);
    i_arp_req_rx  = 1'b1;
    i_arp_req_mac = mac;
    i_arp_req_ip  = ip;
    i_arp_req_tip = tip;
  endtask

  task automatic set_rsp(input logic [47:0] mac, input logic [31:0] ip);
    i_arp_rsp_rx  = 1'b1;
    i_arp_rsp_mac = mac;
    i_arp_rsp_ip  = ip;
  endtask

  // Waits (bounded) for o_tx_start and checks the frame fields; gap = negedges waited.
  task automatic wait_frame(input string tag, input logic [1:0] typ, input logic [47:0] mac,
                            input logic [31:0] ip, input logic [9:0] len, input logic ack,
                            output int gap);
    bit seen = 0;
    gap = 0;
    while (!seen && gap < 200) begin
      @(negedge clk);
      gap++;
      if (o_tx_start) seen = 1;
    end
    chk({tag, ".seen"}, seen, 1);
    if (seen) begin
      chk({tag, ".type"}, o_tx_type, typ);
      chk({tag, ".mac"}, o_tx_mac, mac);
      chk({tag, ".ip"}, o_tx_ip, ip);
      chk({tag, ".len"}, o_tx_len, len);
      chk({tag, ".ack"}, o_udp_ack, ack);
    end
  endtask

  task automatic finish_frame(input string tag, input logic [1:0] typ);
    repeat (2) @(negedge clk);
    chk({tag, ".held"}, o_tx_type, typ);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
    chk({tag, ".cleared"}, o_tx_type, 0);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int starts = 0;
    repeat (n) begin
      @(negedge clk);
      if (o_tx_start) starts++;
    end
    chk(tag, starts, 0);
  endtask

  initial begin
    int gap;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("reset");

    // Resolution then UDP.
    i_udp_req = 1'b1;
    i_udp_len = 10'd100;
    wait_frame("t1.areq", 2'd1, BCAST, CLIENT, 10'd0, 1'b0, gap);
    finish_frame("t1.areq", 2'd1);
    set_rsp(48'h0000_DEAD_BEEF, 32'h0A00_0003);
    @(negedge clk);
    i_arp_rsp_rx = 1'b0;
    chk("t1.badrsp_valid", o_mac_valid, 0);
    set_rsp(48'h0011_2233_44AA, CLIENT);
    @(negedge clk);
    i_arp_rsp_rx = 1'b0;
    chk("t1.valid", o_mac_valid, 1);
    chk("t1.cmac", o_client_mac, 48'h0011_2233_44AA);
    wait_frame("t1.udp", 2'd3, 48'h0011_2233_44AA, CLIENT, 10'd100, 1'b1, gap);
    i_udp_req = 1'b0;
    finish_frame("t1.udp", 2'd3);

    // ARP request for us is answered; other target IPs are not.
    @(negedge clk);
    set_req(48'h00AA_BBCC_DDEE, 32'h0A00_0005, HOST);
    wait_frame("t2.rsp", 2'd2, 48'h00AA_BBCC_DDEE, 32'h0A00_0005, 10'd0, 1'b0, gap);
    i_arp_req_rx = 1'b0;
    finish_frame("t2.rsp", 2'd2);
    set_req(48'h00AA_BBCC_DDEE, 32'h0A00_0005, 32'h0A00_0099);
    @(negedge clk);
    i_arp_req_rx = 1'b0;
    expect_quiet("t2.othertip", 10);

    // Simultaneous UDP + ARP request: response first; latest pending request wins.
    i_udp_req = 1'b1;
    i_udp_len = 10'd64;
    set_req(48'h0000_0000_00B1, 32'h0A00_0007, HOST);
    wait_frame("t3.first", 2'd2, 48'h0000_0000_00B1, 32'h0A00_0007, 10'd0, 1'b0, gap);
    i_arp_req_rx = 1'b0;
    @(negedge clk);
    set_req(48'h0000_0000_00C1, 32'h0A00_0008, HOST);
    @(negedge clk);
    set_req(48'h0000_0000_00C2, 32'h0A00_0009, HOST);
    @(negedge clk);
    i_arp_req_rx = 1'b0;
    finish_frame("t3.first", 2'd2);
    wait_frame("t3.latest", 2'd2, 48'h0000_0000_00C2, 32'h0A00_0009, 10'd0, 1'b0, gap);
    finish_frame("t3.latest", 2'd2);
    wait_frame("t3.udp", 2'd3, 48'h0011_2233_44AA, CLIENT, 10'd64, 1'b1, gap);
    i_udp_req = 1'b0;
    finish_frame("t3.udp", 2'd3);
    expect_quiet("t3.noextra", 20);

    // Reset while waiting for done with a response pending.
    set_req(48'h0000_0000_00A4, 32'h0A00_000A, HOST);
    wait_frame("t4.rsp", 2'd2, 48'h0000_0000_00A4, 32'h0A00_000A, 10'd0, 1'b0, gap);
    i_arp_req_rx = 1'b0;
    @(negedge clk);
    set_req(48'h0000_0000_00A5, 32'h0A00_000B, HOST);
    @(negedge clk);
    i_arp_req_rx = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle_outputs("t4.rst");
    expect_quiet("t4.slot_empty", 10);

    // No reply: three ARP requests 16 wait cycles apart, then failure.
    i_udp_req = 1'b1;
    i_udp_len = 10'd513;
    for (int i = 0; i < 3; i++) begin
      wait_frame($sformatf("t5.areq%0d", i), 2'd1, BCAST, CLIENT, 10'd0, 1'b0, gap);
      chk($sformatf("t5.gap%0d", i), gap, (i == 0) ? 1 : 17);
      finish_frame($sformatf("t5.areq%0d", i), 2'd1);
    end
    expect_quiet("t5.nomore", 40);
    chk("t5.fail", o_arp_fail, 1);
    chk("t5.valid", o_mac_valid, 0);

    // A matching reply clears the failure and lets UDP through.
    set_rsp(48'h0011_2233_44BB, CLIENT);
    @(negedge clk);
    i_arp_rsp_rx = 1'b0;
    chk("t6.fail", o_arp_fail, 0);
    chk("t6.valid", o_mac_valid, 1);
    chk("t6.cmac", o_client_mac, 48'h0011_2233_44BB);
    wait_frame("t6.udp", 2'd3, 48'h0011_2233_44BB, CLIENT, 10'd513, 1'b1, gap);
    i_udp_req = 1'b0;
    finish_frame("t6.udp", 2'd3);

`ifdef ETH_TX_SCHED_CACHE_AGE_EN
    set_rsp(48'h0011_2233_44CC, CLIENT);
    @(negedge clk);
    i_arp_rsp_rx = 1'b0;
    gap = 0;
    while (o_mac_valid && gap < 300) begin
      @(negedge clk);
      gap++;
    end
    chk("t7.age", gap, 100);
    i_udp_req = 1'b1;
    wait_frame("t7.reres", 2'd1, BCAST, CLIENT, 10'd0, 1'b0, gap);
    i_udp_req = 1'b0;
    finish_frame("t7.reres", 2'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
- Transmit scheduler between the Ethernet receive side and the frame builder.
- Owns client-MAC resolution: issues ARP requests with timeout/retry and latches the answering MAC.
- Arbitrates three frame sources (ARP response, ARP request, UDP) onto one frame-builder start/done handshake.
- Holds the target MAC/IP/length fields stable for the whole frame.

Parameters:
- HOST_IP, 32'h0A000021, own IP; ARP responses are only answered for this IP.
- CLIENT_IP, 32'h0A000002, UDP target IP to resolve.
- ARP_TIMEOUT, 125000, cycles to wait for an ARP answer before retrying.
- ARP_RETRIES, 3, ARP requests sent before declaring failure.
- CACHE_AGE, 32'd125000000, cycles a resolved MAC stays valid (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_arp_req_rx  in  1  one-cycle pulse: ARP request received
- i_arp_req_mac  in  48  sender MAC of that request
- i_arp_req_ip  in  32  sender IP of that request
- i_arp_req_tip  in  32  target IP of that request
- i_arp_rsp_rx  in  1  one-cycle pulse: ARP reply received
- i_arp_rsp_mac  in  48  sender MAC of that reply
- i_arp_rsp_ip  in  32  sender IP of that reply
- i_udp_req  in  1  level: UDP frame wanted
- i_udp_len  in  10  UDP payload length
- o_udp_ack  out  1  one-cycle pulse: UDP frame issued
- o_tx_start  out  1  one-cycle pulse to the frame builder
- i_tx_done  in  1  one-cycle pulse: frame fully sent
- o_tx_type  out  2  0 none, 1 ARP request, 2 ARP response, 3 UDP
- o_tx_mac  out  48  destination MAC
- o_tx_ip  out  32  destination IP
- o_tx_len  out  10  payload length (0 for ARP)
- o_client_mac  out  48  resolved client MAC
- o_mac_valid  out  1  o_client_mac is valid
- o_arp_fail  out  1  sticky: retries exhausted

Behaviour:
- Reset: all outputs 0; state IDLE; pending-response slot empty; retry and timer counters 0.
- Input capture:
  - i_arp_req_rx with i_arp_req_tip==HOST_IP loads the single pending-response slot (MAC, IP) and sets its flag.
  - A second request before service overwrites the slot (latest wins).
  - Requests for any other target IP are ignored.
- IDLE arbitration, evaluated every cycle, fixed priority:
  - 1: pending response → frame type 2 to the slot's MAC/IP; slot flag cleared when the frame is issued.
  - 2: i_udp_req && !o_mac_valid && !o_arp_fail → frame type 1 to MAC 48'hFFFFFFFFFFFF, IP CLIENT_IP.
  - 3: i_udp_req && o_mac_valid → frame type 3 to o_client_mac/CLIENT_IP, len = i_udp_len; o_udp_ack pulses the same cycle as o_tx_start.
- ISSUE (one cycle):
  - o_tx_start=1; o_tx_type/mac/ip/len registered.
  - Next state is WAIT_DONE.
- WAIT_DONE:
  - Fields held stable; o_tx_type stays nonzero until i_tx_done.
  - On i_tx_done: go to WAIT_ARP after a type-1 frame (timer cleared), else to IDLE; o_tx_type returns to 0.
- WAIT_ARP:
  - Timer counts up each cycle.
  - i_arp_rsp_rx with i_arp_rsp_ip==CLIENT_IP: latch the MAC, o_mac_valid=1, retries cleared, go to IDLE.
  - A pending response preempts this state: WAIT_ARP is left and the timer resumes from 0 on return.
  - Timer reaching ARP_TIMEOUT-1: retries++.
  - If retries then equals ARP_RETRIES: set o_arp_fail, go to IDLE.
  - Otherwise reissue the ARP request via IDLE.
- Replies outside WAIT_ARP are accepted if their IP matches CLIENT_IP (MAC refresh). Non-matching replies are ignored.
- Simultaneous i_arp_req_rx and i_arp_rsp_rx: both are captured in the same cycle.
- i_tx_done outside WAIT_DONE is ignored.
- o_arp_fail clears only on reset or a matching reply.
- Reset mid-frame returns to IDLE immediately. No o_tx_start is generated in the reset cycle.

Optional Feature:
- Macro ETH_TX_SCHED_CACHE_AGE_EN.
- Defined: an age counter restarts on each MAC latch. At CACHE_AGE, o_mac_valid drops, and the next i_udp_req triggers re-resolution. The UDP frame in flight is unaffected.
- Undefined: o_mac_valid stays set until reset; no age counter is synthesized.

Decomposition:
- Package eth_pkg holds:
  - frame-type codes TX_NONE/TX_ARP_REQ/TX_ARP_RSP/TX_UDP
  - scheduler state encoding IDLE/ISSUE/WAIT_DONE/WAIT_ARP
  - BCAST_MAC constant
- One sub-module, eth_arp_timer: timeout counter plus retry counter with clear/tick inputs and timeout/exhausted outputs.

Test Plan:
- i_udp_req=1, no MAC → type 1, mac FFFFFFFFFFFF, ip 0A000002. i_arp_rsp_rx mac 0011223344AA → o_mac_valid=1 → type 3, mac 0011223344AA, len=i_udp_len, o_udp_ack with o_tx_start.
- ARP request for tip 0A000021 from 00AABBCCDDEE/0A000005 while idle → type 2 to 00AABBCCDDEE/0A000005. Same request with tip 0A000099 → no frame.
- ARP_TIMEOUT=16, ARP_RETRIES=3, no reply → exactly 3 type-1 frames about 16 cycles apart after each done, then o_arp_fail=1 and no UDP frame.
- UDP request and ARP request arrive in the same cycle → type 2 issued first, then type 1/3. Two ARP requests before service → only the latest MAC is answered.
- rst asserted during WAIT_DONE → next cycle all outputs 0, state IDLE, pending slot empty.
- With ETH_TX_SCHED_CACHE_AGE_EN and CACHE_AGE=100 → o_mac_valid drops 100 cycles after the latch; the next i_udp_req produces a type-1 frame.
